// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: issues in-order fetches on a req/gnt/rvalid bus and buffers
// returned words with their addresses in a small FIFO feeding the if_id stage.
module ifu_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_wptr;
    logic [CW-1:0] r_rptr;
    logic [31:0]   r_inst  [DEPTH];
    logic [31:0]   r_iaddr [DEPTH];

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit_used;
    logic          w_req;
    logic          w_grant;
    logic          w_valid;
    logic          w_pop;
    logic          w_drop;
    logic          w_push;
    logic [CW-1:0] w_out_nxt;
    logic [31:0]   w_jump_pc;

    assign w_count       = r_wptr - r_rptr;
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count};
    // Gated by rst so the bus sees no request while the block is held in reset.
    assign w_req         = rst && !jump_flag_i && (w_credit_used < LIMIT);
    assign w_grant       = w_req && ibus_gnt_i;
    assign w_valid       = (w_count != '0);
    assign w_pop         = w_valid && !hold_flag_i && !jump_flag_i;
    assign w_drop        = ibus_rvalid_i && (r_discard != '0);
    assign w_push        = ibus_rvalid_i && (r_discard == '0) && !jump_flag_i;
    assign w_out_nxt     = r_outstanding + CW'(w_grant) - CW'(ibus_rvalid_i);
    assign w_jump_pc     = jump_addr_i & ~32'h3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (jump_flag_i) begin
                // Every response still owed after this cycle belongs to the old stream.
                r_discard  <= w_out_nxt;
                r_fetch_pc <= w_jump_pc;
                r_resp_pc  <= w_jump_pc;
                r_rptr     <= r_wptr;
            end else begin
                r_discard <= r_discard - CW'(w_drop);
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wptr    <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wptr[AW-1:0]]  <= ibus_rdata_i;
            r_iaddr[r_wptr[AW-1:0]] <= r_resp_pc;
        end
    end

    assign ibus_req_o   = w_req;
    assign ibus_addr_o  = r_fetch_pc;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? r_inst[r_rptr[AW-1:0]] : NOP;
    assign inst_addr_o  = w_valid ? r_iaddr[r_rptr[AW-1:0]] : 32'h0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed vector tables, hand-written corner
// sequences and a randomized run against a stream-level reference model.
module tb_ifu_prefetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    ifu_prefetch #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } bus_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          rst_before;
        bit          hold;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_iaddr;
    } vec_t;

    bus_t        bus_q[$];
    ent_t        mq[$];
    int          epoch;
    int          cyc_n;
    logic [31:0] m_fpc;
    bit          exp_req;
    bit          exp_pop;
    int          n_checks;
    int          n_fail;
    vec_t        vt[17];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, " req"}, 32'(ibus_req_o), 32'h0);
        check32({tag, " valid"}, 32'(inst_valid_o), 32'h0);
        check32({tag, " inst"}, inst_o, NOP);
        check32({tag, " inst_addr"}, inst_addr_o, 32'h0);
        check32({tag, " fetch_addr"}, ibus_addr_o, RESET_PC);
    endtask

    // Holds reset for 3 cycles with the bus model cleared, then releases between edges.
    task automatic do_reset();
        rst           = 1'b0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'h0;
        hold_flag_i   = 1'b0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'h0;
        bus_q.delete();
        mq.delete();
        epoch++;
        m_fpc = RESET_PC;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset_outputs("reset");
        end
        rst = 1'b1;
    endtask

    // Drives one cycle's inputs just after a negedge and checks against the model.
    task automatic cyc_begin(input bit j, input logic [31:0] ja, input bit h, input bit g,
                             input bit rv);
        jump_flag_i = j;
        jump_addr_i = ja;
        hold_flag_i = h;
        ibus_gnt_i  = g;
        if (rv && bus_q.size() > 0 && bus_q[0].ready <= cyc_n) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = bus_q[0].addr ^ KEY;
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = $urandom;
        end
        #1;
        exp_req = !j && (bus_q.size() + mq.size() < DEPTH);
        exp_pop = (mq.size() > 0) && !h && !j;
        check32("model req", 32'(ibus_req_o), 32'(exp_req));
        check32("model fetch_addr", ibus_addr_o, m_fpc);
        check32("model valid", 32'(inst_valid_o), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check32("model inst_addr", inst_addr_o, mq[0].addr);
            check32("model inst", inst_o, mq[0].data);
        end else begin
            check32("model inst_addr", inst_addr_o, 32'h0);
            check32("model inst", inst_o, NOP);
        end
    endtask

    task automatic cyc_end();
        bus_t r;
        @(posedge clk);
        r = '{addr: 32'h0, epoch: 0, ready: 0};
        if (ibus_rvalid_i) r = bus_q.pop_front();
        if (exp_pop) void'(mq.pop_front());
        if (ibus_rvalid_i && !jump_flag_i && r.epoch == epoch) begin
            mq.push_back('{addr: r.addr, data: ibus_rdata_i});
        end
        if (jump_flag_i) begin
            mq.delete();
            epoch++;
            m_fpc = {jump_addr_i[31:2], 2'b00};
        end else if (exp_req && ibus_gnt_i) begin
            bus_q.push_back('{addr: m_fpc, epoch: epoch, ready: cyc_n + 1});
            m_fpc = m_fpc + 32'd4;
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run_table();
        for (int i = 0; i < 17; i++) begin
            if (vt[i].rst_before) do_reset();
            cyc_begin(1'b0, 32'h0, vt[i].hold, 1'b1, 1'b1);
            check32($sformatf("vec%0d req", i), 32'(ibus_req_o), 32'(vt[i].exp_req));
            check32($sformatf("vec%0d fetch_addr", i), ibus_addr_o, vt[i].exp_addr);
            check32($sformatf("vec%0d valid", i), 32'(inst_valid_o), 32'(vt[i].exp_valid));
            check32($sformatf("vec%0d inst_addr", i), inst_addr_o, vt[i].exp_iaddr);
            check32($sformatf("vec%0d inst", i), inst_o,
                    vt[i].exp_valid ? (vt[i].exp_iaddr ^ KEY) : NOP);
            cyc_end();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        epoch    = 0;
        cyc_n    = 0;
        rst      = 1'b0;

        // Zero-wait stream, then hold from the first valid instruction.
        vt[0]  = '{1, 0, 1, 32'h00, 0, 32'h00};
        vt[1]  = '{0, 0, 1, 32'h04, 0, 32'h00};
        vt[2]  = '{0, 0, 1, 32'h08, 1, 32'h00};
        vt[3]  = '{0, 0, 1, 32'h0C, 1, 32'h04};
        vt[4]  = '{0, 0, 1, 32'h10, 1, 32'h08};
        vt[5]  = '{0, 0, 1, 32'h14, 1, 32'h0C};
        vt[6]  = '{1, 0, 1, 32'h00, 0, 32'h00};
        vt[7]  = '{0, 0, 1, 32'h04, 0, 32'h00};
        vt[8]  = '{0, 1, 1, 32'h08, 1, 32'h00};
        vt[9]  = '{0, 1, 1, 32'h0C, 1, 32'h00};
        vt[10] = '{0, 1, 0, 32'h10, 1, 32'h00};
        vt[11] = '{0, 1, 0, 32'h10, 1, 32'h00};
        vt[12] = '{0, 0, 0, 32'h10, 1, 32'h00};
        vt[13] = '{0, 0, 1, 32'h10, 1, 32'h04};
        vt[14] = '{0, 0, 1, 32'h14, 1, 32'h08};
        vt[15] = '{0, 0, 1, 32'h18, 1, 32'h0C};
        vt[16] = '{0, 0, 1, 32'h1C, 1, 32'h10};

        do_reset();
        run_table();

        // Grant stall: request and address hold steady.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            check32("stall req", 32'(ibus_req_o), 32'h1);
            check32("stall fetch_addr", ibus_addr_o, 32'h0);
            check32("stall valid", 32'(inst_valid_o), 32'h0);
            cyc_end();
        end

        // Jump with two stale fetches outstanding.
        do_reset();
        cyc_begin(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc_end();
        cyc_begin(1'b1, 32'h103, 1'b0, 1'b1, 1'b0);
        check32("jump cycle req", 32'(ibus_req_o), 32'h0);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check32("post-jump fetch_addr", ibus_addr_o, 32'h100);
        check32("post-jump req", 32'(ibus_req_o), 32'h1);
        cyc_end();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                cyc_begin(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
                if (inst_valid_o) begin
                    seen = 1'b1;
                    check32("first post-jump inst_addr", inst_addr_o, 32'h100);
                end
                cyc_end();
            end
            if (!seen) check32("post-jump valid timeout", 32'h0, 32'h1);
        end

        // Jump coinciding with a response and a pop of 0x4.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            cyc_end();
        end
        cyc_begin(1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
        check32("coinc head addr", inst_addr_o, 32'h4);
        check32("coinc rvalid present", 32'(ibus_rvalid_i), 32'h1);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check32("coinc valid after", 32'(inst_valid_o), 32'h0);
        check32("coinc inst after", inst_o, NOP);
        cyc_end();

        // Asynchronous reset while three entries are buffered.
        do_reset();
        cyc_begin(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check32("pre-reset fifo size", 32'(mq.size()), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        do_reset();
        cyc_begin(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check32("restart fetch_addr", ibus_addr_o, RESET_PC);
        check32("restart req", 32'(ibus_req_o), 32'h1);
        cyc_end();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cyc_begin($urandom_range(0, 99) < 4, $urandom, $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70);
            cyc_end();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Instruction fetch unit with a prefetch FIFO. It sits between the instruction memory bus and the if_id pipeline register, and replaces the direct pc_reg to instruction_mem path. It issues in-order requests on a req/gnt/rvalid instruction bus and buffers the returned words with their addresses. It presents one instruction per cycle to if_id, stalls on hold, and flushes and redirects on jump.

Parameters:
DEPTH, 4, FIFO entries and maximum in-flight plus buffered fetches (power of 2, at least 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset
jump_flag_i  input  1  redirect request from ctrl
jump_addr_i  input  32  redirect target
hold_flag_i  input  1  downstream stall; the head is not consumed
ibus_req_o  output  1  fetch request
ibus_addr_o  output  32  fetch address, word aligned
ibus_gnt_i  input  1  request accepted this cycle
ibus_rvalid_i  input  1  response valid; responses return in order, at least 1 cycle after gnt
ibus_rdata_i  input  32  response instruction
inst_o  output  32  head instruction; 32'h0000_0013 (NOP) when empty
inst_addr_o  output  32  head instruction address; 0 when empty
inst_valid_o  output  1  FIFO not empty

Behaviour:
- Clock and reset: clk is the single clock. rst is asynchronous and active-low. While rst is 0:
  - fetch_pc = RESET_PC and resp_pc = RESET_PC
  - FIFO empty; outstanding = 0; discard = 0
  - ibus_req_o = 0, inst_valid_o = 0, inst_o = NOP, inst_addr_o = 0
- Counters: outstanding and discard are clog2(DEPTH)+1 bits wide.
- Request rule: ibus_req_o = !jump_flag_i && (outstanding + fifo_count < DEPTH). ibus_addr_o = fetch_pc.
- Request stability: once ibus_req_o is high, the address holds until gnt. The only exception is a jump, which drops the request.
- Grant: on req && gnt, fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- Response: on rvalid, outstanding -= 1. Then:
  - If discard > 0: discard -= 1 and the word is dropped.
  - Otherwise: push {ibus_rdata_i, resp_pc} and resp_pc += 4.
- Simultaneous events: gnt and rvalid in the same cycle leave outstanding unchanged.
- Pop: on inst_valid_o && !hold_flag_i && !jump_flag_i, the head is removed.
- Simultaneous push and pop: allowed on a full FIFO. The credit rule guarantees a push never finds the FIFO full with no pop, so there is no overflow.
- Jump (highest priority, one cycle):
  - FIFO cleared.
  - discard = outstanding - (rvalid && discard==0 ? 1 : 0) + discard_residual. Net effect: every response still owed for pre-jump requests is dropped.
  - fetch_pc = resp_pc = {jump_addr_i[31:2], 2'b00}.
  - A response arriving in the jump cycle is dropped.
  - Any pop is cancelled.
  - The first post-jump request is issued in the cycle after the jump.
- Back-to-back jumps: each jump overrides the previous one. Discard accounting stays exact.
- Latency: with a zero-wait bus (gnt in the request cycle, rvalid one cycle later), the first valid instruction appears 2 cycles after the request. Sustained throughput is 1 instruction per cycle.
- Hold: hold_flag_i freezes the head. Requests continue until outstanding + fifo_count = DEPTH, then ibus_req_o drops.
- Mid-operation reset: all state returns to reset values immediately. Responses arriving after reset release for pre-reset requests are a bus error; the bench must reset the bus model together with the block.

Test Plan:
1. Reset and stream: hold rst=0 for 3 cycles, then release; bus gives gnt=1 and rvalid the next cycle with rdata = addr ^ 32'hA5A5_0000 -> ibus_addr_o is 0x0 in the first cycle after release; inst_valid_o rises 2 cycles later; inst_addr_o sequence is 0x0, 0x4, 0x8, 0xC on consecutive cycles with matching inst_o.
2. Hold backpressure: DEPTH=4, hold_flag_i=1 from the first valid instruction -> exactly 4 grants, then ibus_req_o=0; inst_addr_o stays 0x0; on releasing hold, 0x4, 0x8, 0xC drain and fetching resumes at 0x10.
3. Grant stall: ibus_gnt_i=0 for 5 cycles -> ibus_req_o=1 and ibus_addr_o stable at 0x0 throughout; no fifo change.
4. Jump with 2 outstanding: delay rvalid 3 cycles, then pulse jump_flag_i with jump_addr_i=0x103 -> ibus_req_o=0 in the jump cycle; both stale responses are dropped; the next request is 0x100; the first valid instruction has inst_addr_o=0x100.
5. Jump coincident with rvalid and a pop: jump in the same cycle as rvalid and a pop of 0x4 -> no push and no pop; FIFO empty next cycle; inst_o = 32'h0000_0013.
6. Mid-stream reset: assert rst=0 asynchronously between edges while FIFO holds 3 entries -> outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
